// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings and the load/store unit state type.
// Pure declarations: no latency, no flow control.
// Used by lsu, lsu_extend and their bench.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} lsu_state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

    // Unlisted encodings fall through to a full-word access.
    function automatic lsu_size_t f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory request/response bus between the LSU (master) and memory.
// Request held until valid & ready; read data returns on a later rvalid.
// No buffering: the interface carries wires only.
interface lsu_if;
    logic [31:0] busAdr;
    logic [31:0] busWdata;
    logic [3:0]  busBe;
    logic        busWe;
    logic        busValid;
    logic        busReady;
    logic [31:0] busRdata;
    logic        busRvalid;

    modport master (
        output busAdr, busWdata, busBe, busWe, busValid,
        input  busReady, busRdata, busRvalid
    );

    modport slave (
        input  busAdr, busWdata, busBe, busWe, busValid,
        output busReady, busRdata, busRvalid
    );
endinterface

// File: rtl/lsu_extend.sv
// Load lane select plus sign/zero extension of a 32-bit bus word.
// Latency: purely combinational.
// Backpressure: none.
module lsu_extend
    import riscv_pkg::*;
(
    input  logic [31:0] busRdata,
    input  logic [1:0]  adr,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = 8'(busRdata >> {adr, 3'b000});
        lane_h = adr[1] ? busRdata[31:16] : busRdata[15:0];
        case (funct3)
            F3_B:    result = {{24{lane_b[7]}}, lane_b};
            F3_BU:   result = {24'b0, lane_b};
            F3_H:    result = {{16{lane_h[15]}}, lane_h};
            F3_HU:   result = {16'b0, lane_h};
            default: result = busRdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: turns one datapath access into a valid/ready bus transaction (LSU_MISALIGN_TRAP_EN traps misaligned h/w).
// Latency: store 3 cycles, load 4 cycles with zero-wait memory; each bus wait cycle adds one; aborts after TIMEOUT cycles.
// Backpressure: stalls the core while in flight; request held stable until busReady.
module lsu
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] dataAdr,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        stall,
    output logic        misaligned,
    output logic        busErr,
    lsu_if.master       bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    lsu_state_t  state, state_nxt;
    lsu_size_t   size;
    logic        access, mis, trapped, start, tmo, cnt_hit;
    logic [31:0] adr_al, ext, rdata_q, badr_q, wd_q;
    logic [1:0]  lo_q;
    logic [2:0]  f3_q;
    logic [3:0]  be_q;
    logic        we_q, err_q;
    logic [CW-1:0] cnt;

    assign access = memRead | memWrite;
    assign size   = f3_size(funct3);

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis    = (size == SZ_H && dataAdr[0]) || (size == SZ_W && dataAdr[1:0] != 2'b00);
    assign adr_al = dataAdr;
`else
    // Without trapping, the low address bits are forced to natural alignment.
    assign mis    = 1'b0;
    assign adr_al = {dataAdr[31:2],
                     (size == SZ_W) ? 2'b00 : {dataAdr[1], (size == SZ_B) ? dataAdr[0] : 1'b0}};
`endif

    assign trapped    = (state == IDLE) && access && mis;
    assign start      = (state == IDLE) && access && !mis;
    assign misaligned = trapped;
    assign cnt_hit    = (cnt == CW'(TIMEOUT - 1));

    // A trapped load must see zero in the same cycle it is evaluated.
    assign readData = (trapped && !memWrite) ? 32'h0 : rdata_q;
    assign busErr   = err_q;

    assign bus.busAdr   = badr_q;
    assign bus.busWdata = wd_q;
    assign bus.busBe    = be_q;
    assign bus.busWe    = we_q;
    assign bus.busValid = (state == REQ);

    lsu_extend u_extend (
        .busRdata (bus.busRdata),
        .adr      (lo_q),
        .funct3   (f3_q),
        .result   (ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tmo       = 1'b0;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                stall = start;
                if (start) state_nxt = REQ;
            end
            REQ: begin
                stall = 1'b1;
                if (bus.busReady) begin
                    state_nxt = we_q ? DONE : RESP;
                end else if (cnt_hit) begin
                    tmo       = 1'b1;
                    state_nxt = DONE;
                end
            end
            RESP: begin
                stall = 1'b1;
                if (bus.busRvalid) begin
                    state_nxt = DONE;
                end else if (cnt_hit) begin
                    tmo       = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            badr_q  <= '0;
            wd_q    <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            lo_q    <= '0;
            f3_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            err_q <= tmo;
            if (state == REQ || state == RESP) cnt <= cnt + 1'b1;
            else                               cnt <= '0;

            if (start) begin
                badr_q <= {adr_al[31:2], 2'b00};
                lo_q   <= adr_al[1:0];
                f3_q   <= funct3;
                we_q   <= memWrite;
                case (size)
                    SZ_B: begin
                        be_q <= 4'b0001 << adr_al[1:0];
                        wd_q <= {4{writeData[7:0]}};
                    end
                    SZ_H: begin
                        be_q <= 4'b0011 << {adr_al[1], 1'b0};
                        wd_q <= {2{writeData[15:0]}};
                    end
                    default: begin
                        be_q <= 4'b1111;
                        wd_q <= writeData;
                    end
                endcase
            end

            if (state == RESP && bus.busRvalid) rdata_q <= ext;
            else if (tmo)                       rdata_q <= '0;
        end
    end

endmodule
